// File: rtl/loop_ctrl.sv
// Bracket-loop controller: a return-address stack for backward branches (CBB)
// and a nesting counter for forward skips (CBF over a zero cell).
module loop_ctrl #(
  parameter int          PCWidth    = 16,
  parameter int          DataWidth  = 8,
  parameter int          StackDepth = 8,
  parameter int          NestWidth  = 8,
  parameter logic [8:0]  OpCbf      = 9'h05B,  // '['
  parameter logic [8:0]  OpCbb      = 9'h05D,  // ']'
  localparam int         AddrWidth  = $clog2(StackDepth),
  localparam int         CntWidth   = AddrWidth + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [8:0]           instruction,
  input  logic                 instr_valid,
  input  logic                 popBubble,
  input  logic [DataWidth-1:0] working,
  input  logic [PCWidth-1:0]   pc,
  output logic                 searching,
  output logic                 nop,
  output logic                 branch_taken,
  output logic [PCWidth-1:0]   branch_target,
  output logic [CntWidth-1:0]  stack_count,
  output logic [NestWidth-1:0] nest_depth,
  output logic                 fault,
  output logic [1:0]           fault_code
);

  typedef enum logic [1:0] {IDLE, SEARCH, FAULT} state_e;

  state_e                 state_q;
  logic                   searching_q, branch_taken_q, fault_q;
  logic [PCWidth-1:0]     branch_target_q;
  logic [CntWidth-1:0]    stack_count_q;
  logic [NestWidth-1:0]   nest_depth_q;
  logic [1:0]             fault_code_q;
  logic [PCWidth-1:0]     stack_q [StackDepth];

  logic                   accept, is_cbf, is_cbb, w_zero;
  logic                   st_full, st_empty, nest_max, push_en;
  logic [CntWidth-1:0]    top_cnt;
  logic [AddrWidth-1:0]   push_idx, top_idx;

  assign accept   = instr_valid & ~popBubble;
  assign is_cbf   = instruction == OpCbf;
  assign is_cbb   = instruction == OpCbb;
  assign w_zero   = working == '0;
  assign st_full  = stack_count_q == CntWidth'(StackDepth);
  assign st_empty = stack_count_q == '0;
  assign nest_max = &nest_depth_q;
  assign top_cnt  = stack_count_q - CntWidth'(1);
  assign top_idx  = top_cnt[AddrWidth-1:0];
  assign push_idx = stack_count_q[AddrWidth-1:0];
  assign push_en  = (state_q == IDLE) & accept & is_cbf & ~w_zero & ~st_full;

  // Stack contents survive reset; only the occupancy count is cleared.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[push_idx] <= pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      searching_q     <= 1'b0;
      branch_taken_q  <= 1'b0;
      branch_target_q <= '0;
      stack_count_q   <= '0;
      nest_depth_q    <= '0;
      fault_q         <= 1'b0;
      fault_code_q    <= 2'd0;
    end else begin
      branch_taken_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          if (is_cbf) begin
            if (w_zero) begin
              state_q      <= SEARCH;
              searching_q  <= 1'b1;
              nest_depth_q <= '0;
            end else if (st_full) begin
              state_q      <= FAULT;
              fault_q      <= 1'b1;
              fault_code_q <= 2'd1;
            end else begin
              stack_count_q <= stack_count_q + CntWidth'(1);
            end
          end else if (is_cbb) begin
            if (st_empty) begin
              state_q      <= FAULT;
              fault_q      <= 1'b1;
              fault_code_q <= 2'd2;
            end else if (!w_zero) begin
              branch_taken_q  <= 1'b1;
              branch_target_q <= stack_q[top_idx] + PCWidth'(1);
            end else begin
              stack_count_q <= top_cnt;
            end
          end
        end
        // The cell value is irrelevant while skipping; only brackets count.
        SEARCH: if (accept) begin
          if (is_cbf) begin
            if (nest_max) begin
              state_q      <= FAULT;
              searching_q  <= 1'b0;
              fault_q      <= 1'b1;
              fault_code_q <= 2'd3;
            end else begin
              nest_depth_q <= nest_depth_q + NestWidth'(1);
            end
          end else if (is_cbb) begin
            if (nest_depth_q != '0) begin
              nest_depth_q <= nest_depth_q - NestWidth'(1);
            end else begin
              state_q     <= IDLE;
              searching_q <= 1'b0;
            end
          end
        end
        FAULT: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign searching     = searching_q;
  assign nop           = popBubble | searching_q | fault_q;
  assign branch_taken  = branch_taken_q;
  assign branch_target = branch_target_q;
  assign stack_count   = stack_count_q;
  assign nest_depth    = nest_depth_q;
  assign fault         = fault_q;
  assign fault_code    = fault_code_q;

endmodule

// File: doc/loop_ctrl.md
LOOP_CTRL -- requirements
Module: loop_ctrl

Interface
REQ-001 Parameter PCWidth, default 16, program-counter and branch-target width.
REQ-002 Parameter DataWidth, default 8, width of the working-cell value.
REQ-003 Parameter StackDepth, default 8, return-address stack entries (power of two, >=2).
REQ-004 Parameter NestWidth, default 8, forward-search nesting counter width.
REQ-005 Port clk  input  1  sole clock; all state updates on posedge clk.
REQ-006 Port reset  input  1  synchronous, active-high reset.
REQ-007 Port instruction  input  9  current instruction, decoded as op_code from definitions (CBF, CBB; all others "other").
REQ-008 Port instr_valid  input  1  instruction is valid this cycle.
REQ-009 Port popBubble  input  1  pipeline bubble; instruction ignored when 1.
REQ-010 Port working  input  DataWidth  current cell value; "zero" means all bits 0.
REQ-011 Port pc  input  PCWidth  address of the current instruction.
REQ-012 Port searching  output  1  registered; forward search in progress.
REQ-013 Port nop  output  1  combinational: popBubble | searching | fault.
REQ-014 Port branch_taken  output  1  registered one-cycle pulse, backward branch requested.
REQ-015 Port branch_target  output  PCWidth  registered; PC to load when branch_taken=1.
REQ-016 Port stack_count  output  clog2(StackDepth)+1  registered; stack occupancy.
REQ-017 Port nest_depth  output  NestWidth  registered; current search nesting level.
REQ-018 Port fault  output  1  registered, sticky error flag.
REQ-019 Port fault_code  output  2  registered: 0 none, 1 stack overflow, 2 stack underflow, 3 nest overflow.

Function
REQ-020 An instruction is "accepted" only when instr_valid=1 and popBubble=0; non-accepted cycles change no state, and branch_taken is 0 in those cycles.
REQ-021 States: IDLE, SEARCH, FAULT; searching=1 exactly in SEARCH.
REQ-022 IDLE, accepted CBF, working zero: enter SEARCH next cycle, with nest_depth=0 and no push.
REQ-023 IDLE, accepted CBF, working nonzero, stack not full: push pc and increment stack_count; remain in IDLE.
REQ-024 IDLE, accepted CBF, working nonzero, stack full: no push; enter FAULT with fault_code=1.
REQ-025 IDLE, accepted CBB, stack empty: enter FAULT with fault_code=2.
REQ-026 IDLE, accepted CBB, working nonzero: next cycle branch_taken=1 and branch_target=top-of-stack+1 (mod 2^PCWidth); the stack is unchanged.
REQ-027 IDLE, accepted CBB, working zero: pop (stack_count-1); no branch.
REQ-028 SEARCH, accepted CBF: increment nest_depth; if nest_depth is at its maximum, enter FAULT with fault_code=3 instead.
REQ-029 SEARCH, accepted CBB with nest_depth>0: decrement nest_depth.
REQ-030 SEARCH, accepted CBB with nest_depth=0: return to IDLE next cycle; no pop; nop stays 1 in this cycle.
REQ-031 SEARCH, other instructions: ignored; the working value is never examined in SEARCH.
REQ-032 FAULT is absorbing until reset: fault=1 and nop=1; stack, stack_count, nest_depth and fault_code are frozen; branch_taken=0.
REQ-033 branch_taken is never asserted on two consecutive cycles unless two CBB instructions are accepted back-to-back.
REQ-034 Stack storage is a register array indexed by stack_count; no read-during-write hazard, because push and pop never occur in the same cycle.

Reset
REQ-035 reset=1 at a clock edge forces the IDLE state and sets searching=0, branch_taken=0, branch_target=0, stack_count=0, nest_depth=0, fault=0 and fault_code=0; it overrides all other inputs in that cycle.
REQ-036 Reset asserted in SEARCH or FAULT, or with a non-empty stack, discards all state; stack contents need not be cleared.
REQ-037 nop after reset equals popBubble.

Verification
REQ-038 Loop: CBF at pc=0x0010 with working=3, then CBB with working=2 -> next cycle branch_taken=1, branch_target=0x0011, and stack_count stays 1; a following CBB with working=0 -> stack_count=0 and no branch.
REQ-039 Skip: CBF with working=0, then stream CBF, ADD, CBB, CBB -> nest_depth goes 1, 1, 0, and searching=1 through the final CBB, then 0 on the next cycle; nop=1 throughout.
REQ-040 Overflow: StackDepth=2; three CBF with working=1 at pc 1, 2, 3 -> after the third, fault=1, fault_code=1, stack_count=2, and nop stuck at 1.
REQ-041 Underflow: CBB right after reset -> fault=1 and fault_code=2; then reset=1 for one cycle -> all outputs at their reset values.
REQ-042 Bubble: CBF with working=0 presented with popBubble=1 -> searching stays 0 and nop=1 only in that cycle; the same CBF with instr_valid=0 is also ignored.
REQ-043 Reset mid-search: enter SEARCH with nest_depth=2, assert reset -> next cycle searching=0, nest_depth=0, and a subsequent CBB (working=0) faults with fault_code=2.
